// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable down counter / interval timer with one-shot or auto-reload expiry
// Counts a loaded value down to zero on enabled clocks, pulsing done on each expiry or reload.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             down,
  input  logic             auto_rld,
  output logic [WIDTH-1:0] cout,
  output logic             zero,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] rld_q;
  logic [WIDTH-1:0] rld_nxt;
  logic             done_q;
  logic             done_nxt;
  logic             busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt_q  <= '0;
      rld_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt_q  <= cnt_nxt;
      rld_q  <= rld_nxt;
      done_q <= done_nxt;
      busy_q <= (state_nxt == RUN);
    end
  end

  // RUN always holds a nonzero count, so the expiry check only needs cnt_q == 1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    rld_nxt   = rld_q;
    done_nxt  = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (load) begin
      rld_nxt   = load_val;
      cnt_nxt   = load_val;
      state_nxt = (load_val != '0) ? RUN : IDLE;
    end else begin
      case (state)
        RUN: begin
          if (down) begin
            if (cnt_q == ONE) begin
              done_nxt = 1'b1;
              if (auto_rld) begin
                cnt_nxt = rld_q;
              end else begin
                cnt_nxt   = '0;
                state_nxt = EXPIRED;
              end
            end else begin
              cnt_nxt = cnt_q - ONE;
            end
          end
        end
        IDLE, EXPIRED: begin
          cnt_nxt = '0;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    cout = cnt_q;
    zero = (cnt_q == '0);
    done = done_q;
    busy = busy_q;
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - directed and randomized checks of down_counter_timer against a rule-level model
module tb_down_counter_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic         down;
  logic         auto_rld;
  logic [W-1:0] cout;
  logic         zero;
  logic         done;
  logic         busy;

  int total = 0;
  int bad   = 0;

  int m_cnt = 0;
  int m_rld = 0;
  bit m_run = 1'b0;
  bit m_done = 1'b0;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .down     (down),
    .auto_rld (auto_rld),
    .cout     (cout),
    .zero     (zero),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_cout"}, 32'(cout), 32'(m_cnt));
    chk({tag, "_zero"}, 32'(zero), 32'(m_cnt == 0));
    chk({tag, "_done"}, 32'(done), 32'(m_done));
    chk({tag, "_busy"}, 32'(busy), 32'(m_run));
  endtask

  // One clock: drive inputs, apply the behavioural rules to the model, compare after the edge.
  task automatic step(input string tag, input bit c, input bit l, input int lv, input bit d, input bit a);
    clr      = c;
    load     = l;
    load_val = lv[W-1:0];
    down     = d;
    auto_rld = a;
    @(posedge clk);
    if (c) begin
      m_cnt  = 0;
      m_run  = 1'b0;
      m_done = 1'b0;
    end else if (l) begin
      m_rld  = lv % (1 << W);
      m_cnt  = m_rld;
      m_run  = (m_rld != 0);
      m_done = 1'b0;
    end else if (m_run && d && m_cnt == 1) begin
      m_done = 1'b1;
      if (a) begin
        m_cnt = m_rld;
      end else begin
        m_cnt = 0;
        m_run = 1'b0;
      end
    end else begin
      if (m_run && d) m_cnt = m_cnt - 1;
      m_done = 1'b0;
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    int exp4[5];
    int n;
    exp4 = '{8, 7, 7, 7, 6};

    reset    = 1'b0;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = '0;
    down     = 1'b0;
    auto_rld = 1'b0;
    #12;
    chk_all("reset");
    reset = 1'b1;

    // Asynchronous reset in the middle of a count
    step("t1_load", 0, 1, 7, 0, 0);
    step("t1_hold", 0, 0, 0, 0, 0);
    #3 reset = 1'b0;
    #1;
    m_cnt  = 0;
    m_rld  = 0;
    m_run  = 1'b0;
    m_done = 1'b0;
    chk_all("t1_async");
    #1 reset = 1'b1;
    step("t1_after", 0, 0, 0, 1, 0);

    // One-shot count from 5
    step("t2_load", 0, 1, 5, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step("t2_run", 0, 0, 0, 1, 0);
      chk("t2_seq", 32'(cout), 32'(4 - i));
    end
    chk("t2_done_at_zero", 32'(done), 32'd1);
    for (int i = 0; i < 4; i++) step("t2_expired", 0, 0, 0, 1, 0);

    // Auto-reload period of 3
    step("t3_load", 0, 1, 3, 1, 1);
    chk("t3_load_val", 32'(cout), 32'd3);
    for (int i = 0; i < 9; i++) step("t3_run", 0, 0, 0, 1, 1);

    // Gapped enable pattern
    step("t4_load", 0, 1, 9, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step("t4_run", 0, 0, 0, (i == 2 || i == 3) ? 1'b0 : 1'b1, 0);
      chk("t4_seq", 32'(cout), 32'(exp4[i]));
    end

    // Reload mid-count, then clr beating load
    step("t5_load", 0, 1, 4, 0, 0);
    step("t5_dec", 0, 0, 0, 1, 0);
    step("t5_dec", 0, 0, 0, 1, 0);
    chk("t5_at2", 32'(cout), 32'd2);
    step("t5_reload", 0, 1, 12, 1, 0);
    chk("t5_reload_val", 32'(cout), 32'd12);
    step("t5_clr", 1, 1, 5, 1, 0);
    chk("t5_clr_busy", 32'(busy), 32'd0);

    // Zero load and full-scale load
    step("t6_load0", 0, 1, 0, 1, 0);
    step("t6_load15", 0, 1, 15, 1, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step("t6_run", 0, 0, 0, 1, 0);
      n++;
      if (done === 1'b1) break;
    end
    chk("t6_cycles", 32'(n), 32'd15);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(15) == 0),
           ($urandom_range(7) == 0),
           int'($urandom_range(15)),
           ($urandom_range(3) != 0),
           $urandom_range(1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
